// File: rtl/axis_fifo_drain.sv
// Drains a first-word-fall-through FIFO read port into fixed-length AXI-Stream packets,
// flushing a short packet when buffered data has waited TIMEOUT cycles.
module axis_fifo_drain #(
    parameter int unsigned BW       = 8,
    parameter int unsigned LGFLEN   = 4,
    parameter int unsigned LGMAXPKT = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [LGMAXPKT:0]   i_pkt_len,
    input  logic                i_empty,
    input  logic [LGFLEN:0]     i_fill,
    input  logic [BW-1:0]       i_data,
    output logic                o_rd,
    output logic                M_AXIS_TVALID,
    input  logic                M_AXIS_TREADY,
    output logic [BW-1:0]       M_AXIS_TDATA,
    output logic                M_AXIS_TLAST,
    output logic                o_busy
);

    localparam int unsigned LW = LGMAXPKT + 1;
    localparam int unsigned CW = ((LGFLEN > LGMAXPKT) ? LGFLEN : LGMAXPKT) + 1;
    localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [LW-1:0] MaxPkt     = LW'(2 ** LGMAXPKT);
    localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);

    typedef enum logic {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   remaining_q, remaining_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic [BW-1:0]   tdata_q, tdata_d;

    logic [LW-1:0]   sat_len;
    logic [CW-1:0]   fill_ext;
    logic [CW-1:0]   len_ext;
    logic            timeout_hit;
    logic            start;
    logic            rd;

    always_comb begin
        sat_len = i_pkt_len;
        if (i_pkt_len == '0) begin
            sat_len = LW'(1);
        end else if (i_pkt_len > MaxPkt) begin
            sat_len = MaxPkt;
        end
    end

    assign fill_ext    = CW'(i_fill);
    assign len_ext     = CW'(sat_len);
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TimeoutVal);
    assign start       = (state_q == StIdle) && !i_empty && ((fill_ext >= len_ext) || timeout_hit);

    // TREADY feeds the read strobe combinationally so a ready sink sees one beat per cycle.
    assign rd = (state_q == StBurst) && !i_empty && (!tvalid_q || M_AXIS_TREADY) && !i_reset;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;

        unique case (state_q)
            StIdle: begin
                if (i_empty) begin
                    timer_d = '0;
                end else if (timer_q != TimeoutVal) begin
                    timer_d = timer_q + 1'b1;
                end
                if (start) begin
                    remaining_d = (fill_ext < len_ext) ? LW'(fill_ext) : sat_len;
                    timer_d     = '0;
                    state_d     = StBurst;
                end
            end
            StBurst: begin
                timer_d = '0;
                if (rd) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
        endcase

        if (rd) begin
            tvalid_d = 1'b1;
            tdata_d  = i_data;
            tlast_d  = (remaining_q == LW'(1));
        end else if (M_AXIS_TREADY) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            timer_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
        end
    end

    assign o_rd          = rd;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign o_busy        = (state_q == StBurst);

endmodule
